// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-requester I/O bus arbiter:
// bus widths, default phase timings and the bus-cycle state encoding.
package io_bus_arbiter_pkg;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int CW = 3;

    localparam int T_SETUP_DEF  = 1;
    localparam int T_STROBE_DEF = 2;
    localparam int T_HOLD_DEF   = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } bus_state_e;

    // Phase counter load value: the counter runs t-1 down to 0.
    function automatic logic [CW-1:0] phase_load(input int t);
        return CW'(t - 1);
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: masked requests plus last-served pointer
// give a grant index and the pointer value to store on grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic [1:0] ignore,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx,
    output logic       last_nxt
);

    logic [1:0] eff;

    assign eff = req & ~ignore;

    always_comb begin
        gnt_valid = |eff;
        if (eff == 2'b11) begin
            gnt_idx = ~last;
        end else begin
            gnt_idx = eff[1];
        end
        last_nxt = gnt_valid ? gnt_idx : last;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one I/O bus between two requesters: round-robin grant, then a
// fixed setup / strobe / hold bus cycle with registered strobes.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] addr,
    inout  wire  [DW-1:0] data,
    output logic          ior_,
    output logic          iow_
);

    bus_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          g_q, g_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ior_q, ior_d;
    logic          iow_q, iow_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    ack_q, ack_d;

    logic          gnt_valid;
    logic          gnt_idx;
    logic          arb_last;
    logic          grant;

    // A requester being acked this clock is masked so it cannot re-win.
    rr_arbiter2 u_rr (
        .req       ({req1, req0}),
        .ignore    (ack_q),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .last_nxt  (arb_last)
    );

    assign grant = (state_q == ST_IDLE) && gnt_valid;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            g_q     <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            rdata_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            g_q     <= g_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ior_q   <= ior_d;
            iow_q   <= iow_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_SETUP;
                    cnt_d   = phase_load(T_SETUP);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = phase_load(T_STROBE);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = phase_load(T_HOLD);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        g_d     = g_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ior_d   = 1'b1;
        iow_d   = 1'b1;
        rdata_d = rdata_q;
        ack_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    last_d  = arb_last;
                    g_d     = gnt_idx;
                    wr_d    = gnt_idx ? wr1 : wr0;
                    addr_d  = gnt_idx ? addr1 : addr0;
                    wdata_d = gnt_idx ? wdata1 : wdata0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    ior_d = wr_q;
                    iow_d = ~wr_q;
                end
            end
            ST_STROBE: begin
                if (cnt_q != '0) begin
                    ior_d = wr_q;
                    iow_d = ~wr_q;
                end else if (!wr_q) begin
                    rdata_d = data;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    ack_d[g_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign data  = (state_q != ST_IDLE && wr_q) ? wdata_q : 'z;
    assign addr  = addr_q;
    assign ior_  = ior_q;
    assign iow_  = iow_q;
    assign rdata = rdata_q;
    assign ack0  = ack_q[0];
    assign ack1  = ack_q[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized two-requester traffic against a transaction-level model,
// plus directed timing runs on a second instance with non-default phases.
module tb_io_bus_arbiter;

    localparam int TS  = 1;
    localparam int TST = 2;
    localparam int TH  = 1;

    logic clk = 1'b0;
    logic reset_;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Instance A: default timing, random traffic.
    logic [1:0]  req_i;
    logic [1:0]  wr_i;
    logic [15:0] addr_i [2];
    logic [7:0]  wdata_i [2];
    logic        ack_a0, ack_a1, ior_a, iow_a;
    logic [7:0]  rdata_a;
    logic [15:0] addr_a;
    wire  [7:0]  data_a;
    logic [7:0]  dev_mem [256];

    io_bus_arbiter u_dut_a (
        .clock  (clk),
        .reset_ (reset_),
        .req0   (req_i[0]),
        .req1   (req_i[1]),
        .wr0    (wr_i[0]),
        .wr1    (wr_i[1]),
        .addr0  (addr_i[0]),
        .addr1  (addr_i[1]),
        .wdata0 (wdata_i[0]),
        .wdata1 (wdata_i[1]),
        .ack0   (ack_a0),
        .ack1   (ack_a1),
        .rdata  (rdata_a),
        .addr   (addr_a),
        .data   (data_a),
        .ior_   (ior_a),
        .iow_   (iow_a)
    );

    assign data_a = !ior_a ? dev_mem[addr_a[7:0]] : 8'hzz;

    always @(posedge iow_a) begin
        if (reset_) dev_mem[addr_a[7:0]] <= data_a;
    end

    // Instance B: T_SETUP=3, T_STROBE=1, T_HOLD=2, directed.
    logic        req_b, wr_b;
    logic [15:0] addr_b_i;
    logic [7:0]  wdata_b;
    logic        ack_b0, ack_b1, ior_b, iow_b;
    logic [7:0]  rdata_b;
    logic [15:0] addr_b;
    wire  [7:0]  data_b;
    logic [7:0]  dev_b_last;

    io_bus_arbiter #(
        .T_SETUP  (3),
        .T_STROBE (1),
        .T_HOLD   (2)
    ) u_dut_b (
        .clock  (clk),
        .reset_ (reset_),
        .req0   (req_b),
        .req1   (1'b0),
        .wr0    (wr_b),
        .wr1    (1'b0),
        .addr0  (addr_b_i),
        .addr1  (16'h0000),
        .wdata0 (wdata_b),
        .wdata1 (8'h00),
        .ack0   (ack_b0),
        .ack1   (ack_b1),
        .rdata  (rdata_b),
        .addr   (addr_b),
        .data   (data_b),
        .ior_   (ior_b),
        .iow_   (iow_b)
    );

    assign data_b = !ior_b ? 8'h3C : 8'hzz;

    always @(posedge iow_b) begin
        if (reset_) dev_b_last <= data_b;
    end

    // Transaction-level model: m_rem counts edges left until the ack edge.
    logic [7:0]  mmem [256];
    int          m_rem;
    logic        m_g, m_last, m_wr;
    logic [1:0]  m_ack;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;

    task automatic model_reset();
        m_rem   = 0;
        m_g     = 1'b0;
        m_last  = 1'b1;
        m_wr    = 1'b0;
        m_ack   = 2'b00;
        m_addr  = 16'h0000;
        m_wdata = 8'h00;
        m_rdata = 8'h00;
    endtask

    task automatic model_step();
        logic [1:0] nack;
        logic [1:0] el;
        nack = 2'b00;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == TH && !m_wr) m_rdata = mmem[m_addr[7:0]];
            if (m_rem == 0) begin
                nack[m_g] = 1'b1;
                if (m_wr) mmem[m_addr[7:0]] = m_wdata;
            end
        end else begin
            el = req_i & ~m_ack;
            if (el != 2'b00) begin
                m_g     = (el == 2'b11) ? ~m_last : el[1];
                m_last  = m_g;
                m_wr    = wr_i[m_g];
                m_addr  = addr_i[m_g];
                m_wdata = wdata_i[m_g];
                m_rem   = TS + TST + TH;
            end
        end
        m_ack = nack;
    endtask

    always @(posedge clk or negedge reset_) begin
        if (!reset_) model_reset();
        else model_step();
    end

    function automatic logic strobe_win();
        return (m_rem <= TST + TH) && (m_rem > TH);
    endfunction

    task automatic check_a();
        check("ack0", ack_a0, m_ack[0]);
        check("ack1", ack_a1, m_ack[1]);
        check("ior_", ior_a, !(strobe_win() && !m_wr));
        check("iow_", iow_a, !(strobe_win() && m_wr));
        check("addr", addr_a, m_addr);
        check("rdata", rdata_a, m_rdata);
        check("strobe_excl", ior_a | iow_a, 1);
        if (m_rem > 0 && m_wr) check("wdata_bus", data_a, m_wdata);
    endtask

    task automatic new_fields(input int r);
        wr_i[r]    = 1'($urandom_range(0, 1));
        addr_i[r]  = 16'h0100 + 16'($urandom_range(0, 63));
        wdata_i[r] = 8'($urandom);
    endtask

    task automatic run_b(input logic w, input logic [7:0] wd);
        int lat;
        int low;
        @(negedge clk);
        req_b    = 1'b1;
        wr_b     = w;
        addr_b_i = 16'h0120;
        wdata_b  = wd;
        lat = 0;
        low = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 3) addr_b_i = 16'h0777;
            if (!ior_b || !iow_b) begin
                low++;
                check("b_addr_hold", addr_b, 16'h0120);
                if (w) check("b_wdata", data_b, wd);
            end
            if (ack_b0) lat = i;
        end
        req_b = 1'b0;
        check("b_latency", lat, 7);
        check("b_strobe_len", low, 1);
        if (w) check("b_dev_wr", dev_b_last, wd);
        else check("b_rdata", rdata_b, 8'h3C);
    endtask

    initial begin
        int tie_acks;
        int rst_hold;
        bit rst_done;
        logic [1:0] acks;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'($urandom);
            mmem[i]    = dev_mem[i];
        end
        reset_   = 1'b0;
        req_i    = 2'b00;
        wr_i     = 2'b00;
        req_b    = 1'b0;
        wr_b     = 1'b0;
        addr_b_i = 16'h0000;
        wdata_b  = 8'h00;
        for (int r = 0; r < 2; r++) begin
            addr_i[r]  = 16'h0000;
            wdata_i[r] = 8'h00;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_a();
        check("b_rst_ior", ior_b, 1);
        reset_ = 1'b1;
        new_fields(0);
        new_fields(1);
        req_i = 2'b11;
        tie_acks = 0;
        rst_hold = 0;
        rst_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_a();
            acks = {ack_a1, ack_a0};
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset_ = 1'b1;
            end else if (!rst_done && cyc > 1500 && strobe_win()) begin
                #1 reset_ = 1'b0;
                #1;
                check("rst_ior_", ior_a, 1);
                check("rst_iow_", iow_a, 1);
                check("rst_ack", {ack_a1, ack_a0}, 0);
                check("rst_addr", addr_a, 0);
                rst_hold = 2;
                rst_done = 1;
            end
            for (int r = 0; r < 2; r++) begin
                if (acks[r]) begin
                    tie_acks++;
                    if (tie_acks <= 8 || $urandom_range(0, 1) == 1) begin
                        new_fields(r);
                    end else begin
                        req_i[r] = 1'b0;
                    end
                end else if (!req_i[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        new_fields(r);
                        req_i[r] = 1'b1;
                    end
                end else if (m_rem > 0 && m_g == r[0]) begin
                    if ($urandom_range(0, 3) == 0) new_fields(r);
                end
            end
        end
        check("rst_done", 32'(rst_done), 1);
        check("tie_acks_min", 32'(tie_acks >= 8), 1);
        run_b(1'b0, 8'h00);
        run_b(1'b1, 8'hA5);
        run_b(1'b1, 8'h5A);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
